i2c_rd_result_buffer: RTL and testbench

//  Downstream consumer of the two-slave read sequencer's rd_data/valid/done stream.

---
 rtl/i2c_rd_result_buffer_pkg.sv | 17 +
 rtl/i2c_rd_result_buffer_if.sv | 28 ++
 rtl/i2c_rd_result_buffer_fifo.sv | 72 +++++++
 rtl/i2c_rd_result_buffer.sv | 131 +++++++++++++
 tb/tb_i2c_rd_result_buffer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/i2c_rd_result_buffer_pkg.sv
// Shared types and constants for the read-result buffer.
package i2c_rd_result_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ERR     = 2'd2
    } state_t;

    // Stored record is {slave tag, read byte}
    localparam int unsigned REC_W = 9;

    function automatic logic [REC_W-1:0] pack_rec(input logic tag, input logic [7:0] data);
        return {tag, data};
    endfunction

endpackage

// File: rtl/i2c_rd_result_buffer_if.sv
// Sequencer-side capture stream plus consumer-side drain/status signals.
interface i2c_rd_result_buffer_if #(
    parameter int unsigned AW = 3
);
    logic          domain;
    logic          clr;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_done;
    logic [7:0]    out_data;
    logic          out_tag;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          ovf;
    logic [7:0]    txn_cnt;
    logic          txn_done;

    modport slave (
        input  domain, clr, in_data, in_valid, in_done, out_ready,
        output out_data, out_tag, out_valid, level, ovf, txn_cnt, txn_done
    );

    modport master (
        output domain, clr, in_data, in_valid, in_done, out_ready,
        input  out_data, out_tag, out_valid, level, ovf, txn_cnt, txn_done
    );
endinterface

// File: rtl/i2c_rd_result_buffer_fifo.sv
// Generic synchronous FIFO with single-cycle flush and first-word fall-through read.
// Optional macro I2C_RDBUF_ZEROIZE_EN: flush (and reset) also clears every storage entry.
module i2c_rdbuf_fifo
    import i2c_rd_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = REC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_rd,
    input  logic          i_flush,
    output logic [W-1:0]  o_rdata,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [W-1:0]  r_mem [DEPTH];
    logic          w_wr;
    logic          w_rd;

    assign w_wr = i_wr && !i_flush;
    assign w_rd = i_rd && !i_flush;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

`ifdef I2C_RDBUF_ZEROIZE_EN
    // Storage write; flush and reset scrub every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end
`else
    // Storage write; stale entries after a flush are unreachable via the pointers
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end
`endif

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);

endmodule

// File: rtl/i2c_rd_result_buffer.sv
// Tags sequencer read bytes with their slave index, buffers them, counts transactions
// and flushes on a domain change or clear request.
// Optional macro I2C_RDBUF_ZEROIZE_EN: flush also scrubs buffer storage (no port-visible change).
module i2c_rd_result_buffer
    import i2c_rd_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    i2c_rd_result_buffer_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_n;
    logic             r_idx;
    logic             w_idx_n;
    logic             r_ovf;
    logic             w_ovf_n;
    logic             r_domain_q;
    logic             r_txn_done;
    logic [7:0]       r_txn_cnt;
    logic             w_count;

    logic             w_flush;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic             w_rd;
    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_level;
    logic [REC_W-1:0] w_rdata;

    assign w_flush = bus.clr || (bus.domain != r_domain_q);
    assign w_pop   = !w_empty && bus.out_ready;
    assign w_wr    = bus.in_valid && !w_flush && (!w_full || w_pop);
    assign w_drop  = bus.in_valid && !w_flush && w_full && !w_pop;
    assign w_rd    = w_pop && !w_flush;

    i2c_rdbuf_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr),
        .i_wdata (pack_rec(r_idx, bus.in_data)),
        .i_rd    (w_rd),
        .i_flush (w_flush),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state, tag counter, overflow and completion decode; flush overrides everything
    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_ovf_n   = r_ovf || w_drop;
        w_count   = 1'b0;
        if (w_flush) begin
            w_state_n = ST_IDLE;
            w_idx_n   = 1'b0;
            w_ovf_n   = 1'b0;
        end else begin
            if (bus.in_valid) w_idx_n = r_idx + 1'b1;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_done) begin
                            w_count = 1'b1;
                            w_idx_n = 1'b0;
                        end else begin
                            w_state_n = ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (bus.in_done) begin
                        w_state_n = ST_IDLE;
                        w_count   = 1'b1;
                        w_idx_n   = 1'b0;
                    end else if (bus.in_valid && r_idx == 1'b1) begin
                        w_state_n = ST_ERR;
                    end
                end
                ST_ERR: begin
                    w_ovf_n = 1'b1;
                    if (bus.in_done) begin
                        w_state_n = ST_IDLE;
                        w_idx_n   = 1'b0;
                    end
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    // State, tag, sticky overflow, domain history and transaction counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 1'b0;
            r_ovf      <= 1'b0;
            r_domain_q <= 1'b0;
            r_txn_done <= 1'b0;
            r_txn_cnt  <= '0;
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_ovf      <= w_ovf_n;
            r_domain_q <= bus.domain;
            r_txn_done <= w_count;
            r_txn_cnt  <= r_txn_cnt + 8'(w_count);
        end
    end

    // Head record is masked when empty so uninitialised storage never reaches the port
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : w_rdata[7:0];
    assign bus.out_tag   = w_empty ? 1'b0 : w_rdata[8];
    assign bus.level     = w_level;
    assign bus.ovf       = r_ovf;
    assign bus.txn_cnt   = r_txn_cnt;
    assign bus.txn_done  = r_txn_done;

endmodule

// File: tb/tb_i2c_rd_result_buffer.sv
// Scoreboard bench for the read-result buffer: stimulus queues expected records,
// a monitor compares each accepted head record.
module tb_i2c_rd_result_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   n_done = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    i2c_rd_result_buffer_if #(.AW(3)) bus_if ();

    i2c_rd_result_buffer #(.DEPTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic done, input logic store, input logic tag);
        bus_if.in_data  = d;
        bus_if.in_valid = 1'b1;
        bus_if.in_done  = done;
        if (store) exp_q.push_back({tag, d});
        step();
        bus_if.in_valid = 1'b0;
        bus_if.in_done  = 1'b0;
    endtask

    task automatic drain();
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) step();
        check("drain_queue_left", exp_q.size(), 0);
        step();
        check("drain_level", int'(bus_if.level), 0);
        check("drain_out_valid", int'(bus_if.out_valid), 0);
    endtask

    // Scoreboard monitor: every accepted head record must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus_if.out_valid && bus_if.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected actual=%0h required=none @%0t",
                         {bus_if.out_tag, bus_if.out_data}, $time);
            end else begin
                check("pop_record", int'({bus_if.out_tag, bus_if.out_data}), int'(exp_q.pop_front()));
            end
        end
    end

    // Count completion pulses
    always @(negedge clk) begin
        if (bus_if.txn_done) n_done++;
    end

    initial begin
        int base_done;
        bus_if.domain    = 1'b0;
        bus_if.clr       = 1'b0;
        bus_if.in_data   = '0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_done   = 1'b0;
        bus_if.out_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check("rst_level", int'(bus_if.level), 0);
        check("rst_out_valid", int'(bus_if.out_valid), 0);
        check("rst_ovf", int'(bus_if.ovf), 0);
        check("rst_txn_cnt", int'(bus_if.txn_cnt), 0);
        check("rst_txn_done", int'(bus_if.txn_done), 0);
        rst = 1'b0;
        step();

        // 1: two-byte transaction streamed straight through
        send(8'h12, 1'b0, 1'b1, 1'b0);
        send(8'h90, 1'b1, 1'b1, 1'b1);
        check("t1_txn_done_pulse", int'(bus_if.txn_done), 1);
        step();
        check("t1_txn_done_low", int'(bus_if.txn_done), 0);
        drain();
        check("t1_txn_cnt", int'(bus_if.txn_cnt), 1);
        check("t1_done_pulses", n_done, 1);

        // 2: overfill with consumer stalled; 9th byte dropped
        bus_if.out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send(8'hA0 + 8'(2*t), 1'b0, 1'b1, 1'b0);
            send(8'hA1 + 8'(2*t), 1'b1, 1'b1, 1'b1);
        end
        check("t2_level_full", int'(bus_if.level), 8);
        check("t2_ovf_before", int'(bus_if.ovf), 0);
        send(8'hC9, 1'b1, 1'b0, 1'b0);
        step();
        check("t2_level_after_drop", int'(bus_if.level), 8);
        check("t2_ovf_after", int'(bus_if.ovf), 1);
        check("t2_txn_cnt", int'(bus_if.txn_cnt), 6);
        drain();
        bus_if.clr = 1'b1;
        step();
        bus_if.clr = 1'b0;
        check("t2_clr_ovf", int'(bus_if.ovf), 0);
        check("t2_clr_txn_cnt", int'(bus_if.txn_cnt), 6);

        // 3: full FIFO, write and pop together
        bus_if.out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send(8'hB0 + 8'(2*t), 1'b0, 1'b1, 1'b0);
            send(8'hB1 + 8'(2*t), 1'b1, 1'b1, 1'b1);
        end
        check("t3_level_full", int'(bus_if.level), 8);
        bus_if.out_ready = 1'b1;
        send(8'hB8, 1'b0, 1'b1, 1'b0);
        bus_if.out_ready = 1'b0;
        check("t3_level_kept", int'(bus_if.level), 8);
        check("t3_ovf_kept", int'(bus_if.ovf), 0);
        check("t3_txn_cnt", int'(bus_if.txn_cnt), 10);
        drain();
        bus_if.clr = 1'b1;
        step();
        bus_if.clr = 1'b0;

        // 4: domain change flushes buffered bytes
        bus_if.out_ready = 1'b0;
        send(8'hD0, 1'b0, 1'b1, 1'b0);
        send(8'hD1, 1'b1, 1'b1, 1'b1);
        send(8'hD2, 1'b0, 1'b1, 1'b0);
        send(8'hD3, 1'b1, 1'b1, 1'b1);
        check("t4_level_before", int'(bus_if.level), 4);
        bus_if.domain = 1'b1;
        exp_q.delete();
        step();
        check("t4_out_valid", int'(bus_if.out_valid), 0);
        check("t4_level", int'(bus_if.level), 0);
        check("t4_txn_cnt", int'(bus_if.txn_cnt), 12);
`ifdef I2C_RDBUF_ZEROIZE_EN
        for (int i = 0; i < 8; i++) check("t4_zeroize", int'(dut.u_fifo.r_mem[i]), 0);
`endif
        step();
        check("t4_level_stays", int'(bus_if.level), 0);

        // 5: three bytes without completion -> error, then completion is not counted
        bus_if.out_ready = 1'b1;
        base_done = n_done;
        send(8'h31, 1'b0, 1'b1, 1'b0);
        send(8'h32, 1'b0, 1'b1, 1'b1);
        send(8'h33, 1'b0, 1'b1, 1'b0);
        step();
        check("t5_ovf_err", int'(bus_if.ovf), 1);
        send(8'h34, 1'b1, 1'b1, 1'b1);
        step();
        check("t5_txn_cnt_kept", int'(bus_if.txn_cnt), 12);
        check("t5_no_pulse", n_done - base_done, 0);
        send(8'h35, 1'b1, 1'b1, 1'b0);
        step();
        check("t5_single_counted", int'(bus_if.txn_cnt), 13);
        check("t5_single_pulse", n_done - base_done, 1);
        drain();

        // 6: asynchronous reset mid-transaction
        bus_if.out_ready = 1'b0;
        base_done = n_done;
        send(8'h41, 1'b0, 1'b0, 1'b0);
        check("t6_level_one", int'(bus_if.level), 1);
        bus_if.in_data  = 8'h42;
        bus_if.in_valid = 1'b1;
        bus_if.in_done  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("t6_level", int'(bus_if.level), 0);
        check("t6_out_valid", int'(bus_if.out_valid), 0);
        check("t6_out_data", int'(bus_if.out_data), 0);
        check("t6_out_tag", int'(bus_if.out_tag), 0);
        check("t6_ovf", int'(bus_if.ovf), 0);
        check("t6_txn_cnt", int'(bus_if.txn_cnt), 0);
        check("t6_txn_done", int'(bus_if.txn_done), 0);
        bus_if.in_valid = 1'b0;
        bus_if.in_done  = 1'b0;
        repeat (3) step();
        check("t6_no_pulse", n_done - base_done, 0);
        rst = 1'b0;
        repeat (2) step();
        check("t6_level_after", int'(bus_if.level), 0);
        check("end_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
